// File: rtl/board_attack.sv
// board_attack: computes, for a latched chess board, the set of squares
// attacked by each colour. One square is examined per clock (64 clocks of
// scan after a one-clock latch), so the maps become valid 65 clocks after
// the start request is sampled.
// Optional feature: define BOARD_ATTACK_DISPLAY_EN (with DO_DISPLAY != 0)
// to print both maps once per completed scan and pulse
// display_attacking_done.

`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif

module board_attack #(
    parameter int PIECE_WIDTH = `PIECE_BITS,
    parameter int SIDE_WIDTH  = PIECE_WIDTH*8,
    parameter int BOARD_WIDTH = SIDE_WIDTH*8,
    parameter int DO_DISPLAY  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   board_valid,
    output logic [63:0]            white_is_attacking,
    output logic [63:0]            black_is_attacking,
    output logic                   is_attacking_done,
    output logic                   display_attacking_done
);

    // Square code layout: MSB is colour, remaining bits are piece type.
    localparam int TYPE_W    = PIECE_WIDTH - 1;
    localparam int BLACK_BIT = PIECE_WIDTH - 1;
    localparam logic [PIECE_WIDTH-1:0] EMPTY_POSN = '0;
    localparam logic [TYPE_W-1:0] PIECE_PAWN = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] PIECE_KNIT = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] PIECE_BISH = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] PIECE_ROOK = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] PIECE_QUEN = TYPE_W'(5);
    localparam logic [TYPE_W-1:0] PIECE_KING = TYPE_W'(6);

    typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;

    state_t                 r_state;
    logic [BOARD_WIDTH-1:0] r_board;
    logic [5:0]             r_idx;
    logic [63:0]            r_white;
    logic [63:0]            r_black;
    logic                   r_done;

    logic [PIECE_WIDTH-1:0] w_sq [64];
    logic [63:0]            w_occ;
    logic [PIECE_WIDTH-1:0] w_piece;
    logic [63:0]            w_mask;

    // Single-square target; anything off the board contributes nothing.
    function automatic logic [63:0] f_step(input int row, input int col,
                                           input int dr, input int dc);
        int r;
        int c;
        r = row + dr;
        c = col + dc;
        if (r >= 0 && r < 8 && c >= 0 && c < 8)
            return 64'd1 << (r*8 + c);
        return '0;
    endfunction

    // Sliding ray: includes the first occupied square, then stops.
    function automatic logic [63:0] f_ray(input logic [63:0] occ, input int row,
                                          input int col, input int dr, input int dc);
        logic [63:0] m;
        logic        blocked;
        int          r;
        int          c;
        m       = '0;
        blocked = 1'b0;
        for (int s = 1; s < 8; s++) begin
            r = row + s*dr;
            c = col + s*dc;
            if (!blocked && r >= 0 && r < 8 && c >= 0 && c < 8) begin
                m = m | (64'd1 << (r*8 + c));
                if (occ[6'(r*8 + c)])
                    blocked = 1'b1;
            end
        end
        return m;
    endfunction

    // Attack set of one piece standing on square sq.
    function automatic logic [63:0] f_attacks(input logic [63:0] occ,
                                              input logic [TYPE_W-1:0] ptype,
                                              input logic black, input logic [5:0] sq);
        logic [63:0] m;
        logic [63:0] orth;
        logic [63:0] diag;
        int          row;
        int          col;
        int          fwd;
        row  = int'(sq[5:3]);
        col  = int'(sq[2:0]);
        fwd  = black ? -1 : 1;
        orth = f_ray(occ, row, col, 1, 0) | f_ray(occ, row, col, -1, 0) |
               f_ray(occ, row, col, 0, 1) | f_ray(occ, row, col, 0, -1);
        diag = f_ray(occ, row, col, 1, 1) | f_ray(occ, row, col, 1, -1) |
               f_ray(occ, row, col, -1, 1) | f_ray(occ, row, col, -1, -1);
        case (ptype)
            PIECE_PAWN: m = f_step(row, col, fwd, -1) | f_step(row, col, fwd, 1);
            PIECE_KNIT: m = f_step(row, col, 1, 2)  | f_step(row, col, 1, -2)  |
                            f_step(row, col, -1, 2) | f_step(row, col, -1, -2) |
                            f_step(row, col, 2, 1)  | f_step(row, col, 2, -1)  |
                            f_step(row, col, -2, 1) | f_step(row, col, -2, -1);
            PIECE_KING: m = f_step(row, col, 1, -1)  | f_step(row, col, 1, 0)  |
                            f_step(row, col, 1, 1)   | f_step(row, col, 0, -1) |
                            f_step(row, col, 0, 1)   | f_step(row, col, -1, -1) |
                            f_step(row, col, -1, 0)  | f_step(row, col, -1, 1);
            PIECE_BISH: m = diag;
            PIECE_ROOK: m = orth;
            PIECE_QUEN: m = orth | diag;
            default:    m = '0;
        endcase
        return m;
    endfunction

    // Unpack the latched board into per-square codes and an occupancy map.
    for (genvar gi = 0; gi < 64; gi++) begin : g_sq
        assign w_sq[gi]  = r_board[(gi/8)*SIDE_WIDTH + (gi%8)*PIECE_WIDTH +: PIECE_WIDTH];
        assign w_occ[gi] = (w_sq[gi] != EMPTY_POSN);
    end

    // Attack set of the square currently being scanned.
    always_comb begin
        w_piece = w_sq[r_idx];
        w_mask  = f_attacks(w_occ, w_piece[TYPE_W-1:0], w_piece[BLACK_BIT], r_idx);
    end

    // Control FSM: latch board, scan 64 squares, hold results in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_board <= '0;
            r_idx   <= '0;
            r_white <= '0;
            r_black <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (board_valid) begin
                        r_state <= LATCH;
                        r_done  <= 1'b0;
                    end
                end
                LATCH: begin
                    r_board <= board;
                    r_white <= '0;
                    r_black <= '0;
                    r_idx   <= '0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    if (w_piece[BLACK_BIT])
                        r_black <= r_black | w_mask;
                    else
                        r_white <= r_white | w_mask;
                    if (r_idx == 6'd63) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                    r_idx <= r_idx + 6'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign white_is_attacking = r_white;
    assign black_is_attacking = r_black;
    assign is_attacking_done  = r_done;

`ifdef BOARD_ATTACK_DISPLAY_EN
    logic r_done_dly;
    logic r_disp_done;

    // Print both maps once, the clock after a scan completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_dly  <= 1'b0;
            r_disp_done <= 1'b0;
        end else begin
            r_done_dly  <= r_done;
            r_disp_done <= 1'b0;
            if (DO_DISPLAY != 0 && r_done && !r_done_dly) begin
                r_disp_done <= 1'b1;
                $display("white attacks:");
                for (int r = 7; r >= 0; r--) begin
                    for (int c = 0; c < 8; c++)
                        $write("%s", r_white[r*8 + c] ? "1" : ".");
                    $write("\n");
                end
                $display("black attacks:");
                for (int r = 7; r >= 0; r--) begin
                    for (int c = 0; c < 8; c++)
                        $write("%s", r_black[r*8 + c] ? "1" : ".");
                    $write("\n");
                end
            end
        end
    end

    assign display_attacking_done = r_disp_done;
`else
    logic w_unused_disp;
    assign w_unused_disp          = (DO_DISPLAY != 0);
    assign display_attacking_done = 1'b0;
`endif

endmodule

// File: tb/tb_board_attack.sv
// Testbench for board_attack: random and hand-built boards checked against a
// target-centric reference model (for every square, does any piece reach it).
module tb_board_attack;

    localparam int PW = 4;
    localparam int BW = PW*64;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] board;
    logic          board_valid;
    logic [63:0]   white_is_attacking;
    logic [63:0]   black_is_attacking;
    logic          is_attacking_done;
    logic          display_attacking_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_attack dut (
        .clk                    (clk),
        .reset                  (reset),
        .board                  (board),
        .board_valid            (board_valid),
        .white_is_attacking     (white_is_attacking),
        .black_is_attacking     (black_is_attacking),
        .is_attacking_done      (is_attacking_done),
        .display_attacking_done (display_attacking_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Does the piece on square s attack square t?
    function automatic bit sees(input logic [BW-1:0] b, input int s, input int t);
        logic [3:0] code;
        int dr, dc, ar, ac, sr, sc, n;
        bit line;
        code = b[s*PW +: PW];
        dr = t/8 - s/8;
        dc = t%8 - s%8;
        ar = (dr < 0) ? -dr : dr;
        ac = (dc < 0) ? -dc : dc;
        line = 1'b0;
        if (t == s || code == 4'd0) return 1'b0;
        case (code[2:0])
            3'd1: return (ac == 1) && (dr == (code[3] ? -1 : 1));
            3'd2: return (ar*ac == 2);
            3'd6: return (ar <= 1) && (ac <= 1);
            3'd3: line = (ar == ac);
            3'd4: line = ((dr == 0) != (dc == 0));
            3'd5: line = (ar == ac) || ((dr == 0) != (dc == 0));
            default: return 1'b0;
        endcase
        if (!line) return 1'b0;
        sr = (dr > 0) ? 1 : (dr < 0) ? -1 : 0;
        sc = (dc > 0) ? 1 : (dc < 0) ? -1 : 0;
        n  = (ar > ac) ? ar : ac;
        for (int k = 1; k < n; k++)
            if (b[((s/8 + k*sr)*8 + (s%8 + k*sc))*PW +: PW] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model(input logic [BW-1:0] b, output logic [63:0] w, output logic [63:0] k);
        w = '0;
        k = '0;
        for (int s = 0; s < 64; s++)
            for (int t = 0; t < 64; t++)
                if (sees(b, s, t)) begin
                    if (b[s*PW + PW - 1]) k[t] = 1'b1;
                    else                  w[t] = 1'b1;
                end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int sq, input logic [3:0] code);
        b[sq*PW +: PW] = code;
        return b;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        b = '0;
        for (int sq = 0; sq < 64; sq++)
            if ($urandom_range(3) == 0)
                b[sq*PW +: PW] = {1'($urandom_range(1)), 3'($urandom_range(6, 1))};
        return b;
    endfunction

    // Cycle-level expectation tracker plus per-cycle compare.
    bit          m_armed = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_known = 1'b0;
    int          m_cnt   = 0;
    logic [63:0] m_w = '0, m_b = '0, p_w = '0, p_b = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_armed = 1'b1;
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_known = 1'b1;
                m_w     = '0;
                m_b     = '0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == 65) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_known = 1'b1;
                    m_w     = p_w;
                    m_b     = p_b;
                end
            end else if (board_valid) begin
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_done  = 1'b0;
                m_known = 1'b0;
                model(board, p_w, p_b);
            end
            #1;
            if (m_armed) begin
                chk("cyc_done", 64'(is_attacking_done), 64'(m_done));
                chk("cyc_disp", 64'(display_attacking_done), 64'd0);
                if (m_known) begin
                    chk("cyc_white", white_is_attacking, m_w);
                    chk("cyc_black", black_is_attacking, m_b);
                end
            end
        end
    end

    task automatic start(input logic [BW-1:0] b);
        @(negedge clk);
        board       = b;
        board_valid = 1'b1;
        @(negedge clk);
        board_valid = 1'b0;
    endtask

    // Waits for done, optionally pokes a spurious start at cycle poke_at.
    task automatic wait_done(input int poke_at, output int lat);
        lat = 0;
        while (!is_attacking_done && lat < 200) begin
            @(negedge clk);
            lat++;
            board_valid = (lat == poke_at);
            if (lat == poke_at) board = rand_board();
        end
        board_valid = 1'b0;
        chk("done_timeout", 64'(is_attacking_done), 64'd1);
    endtask

    task automatic run(input string nm, input logic [BW-1:0] b, input int poke_at,
                       input bit use_lit, input logic [63:0] lit_w, input logic [63:0] lit_b);
        int lat;
        logic [63:0] mw, mb;
        start(b);
        wait_done(poke_at, lat);
        chk({nm, "_latency"}, 64'(lat), 64'd65);
        if (use_lit) begin
            model(b, mw, mb);
            chk({nm, "_model_w"}, mw, lit_w);
            chk({nm, "_model_b"}, mb, lit_b);
            chk({nm, "_dut_w"}, white_is_attacking, lit_w);
            chk({nm, "_dut_b"}, black_is_attacking, lit_b);
        end
        $display("run %s latency=%0d white=%h black=%h", nm, lat,
                 white_is_attacking, black_is_attacking);
    endtask

    initial begin
        logic [BW-1:0] b;
        reset       = 1'b1;
        board_valid = 1'b0;
        board       = '0;
        repeat (3) @(negedge clk);
        chk("reset_done", 64'(is_attacking_done), 64'd0);
        chk("reset_white", white_is_attacking, 64'd0);
        chk("reset_black", black_is_attacking, 64'd0);
        reset = 1'b0;

        run("empty", '0, 0, 1'b1, 64'h0, 64'h0);
        run("rook_a1", put('0, 0, 4'h4), 0, 1'b1, 64'h01010101010101FE, 64'h0);
        run("knight_b1", put('0, 1, 4'h2), 0, 1'b1, 64'h0000000000050800, 64'h0);
        b = put(put('0, 0, 4'h4), 16, 4'h1);
        run("rook_pawn", b, 0, 1'b1, 64'h00000000020101FE, 64'h0);
        run("bpawn_e7", put('0, 52, 4'h9), 0, 1'b1, 64'h0, 64'h0000280000000000);
        run("wpawn_a2", put('0, 8, 4'h1), 0, 1'b1, 64'h0000000000020000, 64'h0);
        run("bking_h8", put('0, 63, 4'hE), 0, 1'b1, 64'h0, 64'h40C0000000000000);

        for (int i = 0; i < 20; i++)
            run($sformatf("rand%0d", i), rand_board(), 0, 1'b0, '0, '0);

        run("mid_valid", rand_board(), 20, 1'b0, '0, '0);

        // Reset in the middle of a scan must abort it.
        start(rand_board());
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("abort_done", 64'(is_attacking_done), 64'd0);
        chk("abort_white", white_is_attacking, 64'd0);
        chk("abort_black", black_is_attacking, 64'd0);
        $display("run abort done=%0b", is_attacking_done);

        run("after_abort", rand_board(), 0, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
